// File: rtl/pipe_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_if
//   Bundles the hazard/MDU request lines and the pipeline enable/bubble
//   controls exchanged between the 5-stage pipeline and pipe_stall_ctrl.
//
//   Requests (pipeline -> controller):
//     hz_stall_D    load-use / forwarding-impossible stall request
//     mdu_use_D     instruction in D touches the MDU or HI/LO
//     mdu_start_E   mult/div issuing in E this cycle (one-cycle pulse)
//     mdu_is_div_E  qualifies mdu_start_E: 1 = div/divu, 0 = mult/multu
//   Controls (controller -> pipeline):
//     pc_en, ifid_en  PC and IF/ID write enables
//     idex_clr        ID/EX synchronous clear (NOP bubble)
//     mdu_busy        MDU occupied (combinational)
//     mdu_done        one-cycle registered pulse, HI/LO result final
//     mdu_cnt         remaining busy cycles, 0 when idle
//
//   modport master : pipeline side
//   modport slave  : stall controller side
// -----------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             hz_stall_D;
    logic             mdu_use_D;
    logic             mdu_start_E;
    logic             mdu_is_div_E;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_clr;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] mdu_cnt;

    modport master (
        output hz_stall_D, mdu_use_D, mdu_start_E, mdu_is_div_E,
        input  pc_en, ifid_en, idex_clr, mdu_busy, mdu_done, mdu_cnt
    );

    modport slave (
        input  hz_stall_D, mdu_use_D, mdu_start_E, mdu_is_div_E,
        output pc_en, ifid_en, idex_clr, mdu_busy, mdu_done, mdu_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall/bubble controller for the 5-stage pipeline. Merges the
//   decode-stage load-use stall with a multi-cycle MDU busy sequencer and
//   produces the PC enable, IF/ID enable and ID/EX bubble clear. EX/MEM and
//   MEM/WB always advance; they are not controlled here.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    pipe_stall_ctrl_if.slave (requests in, enables/status out)
//     stall_cycles      [31:0] (PIPE_STALL_CNT_EN only) total stalled edges
//     mdu_stall_cycles  [31:0] (PIPE_STALL_CNT_EN only) edges stalled purely
//                              on the MDU (no load-use stall at the same time)
//
//   Optional feature macro: PIPE_STALL_CNT_EN (performance counters).
//
//   Parameters:
//     MULT_LAT  busy cycles for mult/multu (1..2^CNT_W-1)
//     DIV_LAT   busy cycles for div/divu   (1..2^CNT_W-1)
//     CNT_W     width of the busy countdown
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stall_ctrl_if.slave   bus
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        mdu_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    logic             mdu_busy;
    logic             stall;

    // -------------------------------------------------------------------------
    // MDU busy sequencer. The start edge loads the latency, so BUSY covers
    // exactly LAT cycles after it. A start seen while BUSY cannot happen in a
    // legal program (D is held), so it is dropped rather than reloading.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mdu_start_E) begin
                        cnt_q   <= bus.mdu_is_div_E ? DIV_LOAD : MULT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The issuing cycle already counts as busy so an mflo right behind a
    // mult is held without waiting for the state register to flip.
    assign mdu_busy = (state_q == BUSY) | bus.mdu_start_E;

    // Either cause yields one stall; ORing keeps it to a single bubble.
    assign stall = bus.hz_stall_D | (bus.mdu_use_D & mdu_busy);

    assign bus.pc_en    = ~stall;
    assign bus.ifid_en  = ~stall;
    assign bus.idex_clr = stall;
    assign bus.mdu_busy = mdu_busy;
    assign bus.mdu_done = done_q;
    assign bus.mdu_cnt  = cnt_q;

`ifdef PIPE_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Stall performance counters, free-running with natural 32-bit wrap.
    // The MDU counter excludes cycles already stalled by the hazard unit so
    // the two sources are not double-attributed.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] mdu_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q     <= '0;
            mdu_stall_cnt_q <= '0;
        end else begin
            if (stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.mdu_use_D & mdu_busy & ~bus.hz_stall_D)
                mdu_stall_cnt_q <= mdu_stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles     = stall_cnt_q;
    assign mdu_stall_cycles = mdu_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;
    localparam int VW       = 5 + CNT_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles, mdu_stall_cycles;
`endif

    pipe_stall_ctrl #(
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .mdu_stall_cycles (mdu_stall_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Timeline model: an accepted op occupies cycles [start+1, busy_end],
    // the result is announced at busy_end+1. Cycle numbers are absolute.
    int  t        = 0;
    int  busy_end = -100;
    int  done_at  = -100;
    logic [31:0] m_stall = 0;
    logic [31:0] m_mdu   = 0;

    bit  c_hz, c_use, c_st, c_dv, c_rst;
    logic [VW-1:0] exp_v, got_v;
    bit  e_stall, e_busy, e_done;
    int  e_cnt;

    // Drive one cycle of inputs at the falling edge and compute expectations.
    task automatic drive(input bit hz, input bit use_, input bit st, input bit dv, input bit rst);
        bit in_busy;
        @(negedge clk);
        c_hz = hz; c_use = use_; c_st = st; c_dv = dv; c_rst = rst;
        bus.hz_stall_D   = hz;
        bus.mdu_use_D    = use_;
        bus.mdu_start_E  = st;
        bus.mdu_is_div_E = dv;
        reset            = rst;
        #1;
        in_busy = (t <= busy_end);
        e_cnt   = in_busy ? (busy_end - t + 1) : 0;
        e_busy  = in_busy | st;
        e_done  = (t == done_at);
        e_stall = hz | (use_ & e_busy);
        exp_v = {~e_stall, ~e_stall, e_stall, e_busy, e_done, CNT_W'(e_cnt)};
        got_v = {bus.pc_en, bus.ifid_en, bus.idex_clr, bus.mdu_busy, bus.mdu_done, bus.mdu_cnt};
    endtask

    // Advance the model across the upcoming rising edge.
    task automatic advance();
        bit in_busy;
        in_busy = (t <= busy_end);
        if (c_rst) begin
            busy_end = -100; done_at = -100;
            m_stall = 0; m_mdu = 0;
        end else begin
            if (e_stall) m_stall = m_stall + 1;
            if (c_use && e_busy && !c_hz) m_mdu = m_mdu + 1;
            if (c_st && !in_busy) begin
                busy_end = t + (c_dv ? DIV_LAT : MULT_LAT);
                done_at  = busy_end + 1;
            end
        end
        t++;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 1); advance();
        drive(0, 0, 0, 0, 1); advance();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            tests++;
            if ({bus.pc_en, bus.idex_clr, bus.mdu_busy, bus.mdu_done, bus.mdu_cnt} !== {4'b1000, CNT_W'(0)}) begin
                fails++; $display("FAIL reset_const k=%0d got=%b", k, {bus.pc_en, bus.idex_clr, bus.mdu_busy, bus.mdu_done, bus.mdu_cnt});
            end
            advance();
        end
    endtask

    task automatic test_hz_stall();
        for (int k = 0; k < 5; k++) begin
            drive(k == 1 || k == 2, 0, 0, 0, 0);
            tests++;
            if (got_v !== exp_v || bus.idex_clr !== (k == 1 || k == 2) || bus.mdu_busy !== 1'b0) begin
                fails++; $display("FAIL hz_stall k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_mult();
        drive(0, 0, 0, 0, 1); advance();
        for (int k = 0; k <= 7; k++) begin
            drive(0, 1, k == 0, 0, 0);
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL mult k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            tests++;
            if (bus.idex_clr !== (k <= 5) || bus.mdu_done !== (k == 6) ||
                bus.mdu_cnt !== CNT_W'((k >= 1 && k <= 5) ? 6 - k : 0)) begin
                fails++; $display("FAIL mult_const k=%0d clr=%b done=%b cnt=%0d", k, bus.idex_clr, bus.mdu_done, bus.mdu_cnt);
            end
`ifdef PIPE_STALL_CNT_EN
            tests++;
            if (stall_cycles !== m_stall || mdu_stall_cycles !== m_mdu) begin
                fails++; $display("FAIL mult_perf k=%0d got=%0d/%0d exp=%0d/%0d", k, stall_cycles, mdu_stall_cycles, m_stall, m_mdu);
            end
            if (k == 7) begin
                tests++;
                if (stall_cycles !== 32'd6 || mdu_stall_cycles !== 32'd6) begin
                    fails++; $display("FAIL mult_perf_total got=%0d/%0d exp=6/6", stall_cycles, mdu_stall_cycles);
                end
            end
`endif
            advance();
        end
    endtask

    task automatic test_div();
        for (int k = 0; k <= 12; k++) begin
            drive(0, 0, k == 0, 1, 0);
            tests++;
            if (got_v !== exp_v || bus.pc_en !== 1'b1 || bus.mdu_done !== (k == 11) ||
                bus.mdu_cnt !== CNT_W'((k >= 1 && k <= 10) ? 11 - k : 0)) begin
                fails++; $display("FAIL div k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            advance();
        end
    endtask

    // div, new mult issued in the div's done cycle, illegal start mid-mult.
    task automatic test_back_to_back();
        for (int k = 0; k <= 18; k++) begin
            drive(0, 0, (k == 0) || (k == 11) || (k == 13), (k == 0) || (k == 13), 0);
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL b2b k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            if (k == 11 || k == 12 || k == 14 || k == 17) begin
                tests++;
                if ((k == 11 && bus.mdu_done !== 1'b1) || (k == 12 && bus.mdu_cnt !== 4'd5) ||
                    (k == 14 && bus.mdu_cnt !== 4'd3) || (k == 17 && bus.mdu_done !== 1'b1)) begin
                    fails++; $display("FAIL b2b_const k=%0d done=%b cnt=%0d", k, bus.mdu_done, bus.mdu_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_busy();
        for (int k = 0; k <= 9; k++) begin
            drive(0, 1, k == 0, 0, k == 3);
            tests++;
            if (got_v !== exp_v || (k >= 4 && (bus.mdu_cnt !== '0 || bus.mdu_done !== 1'b0)) ||
                (k == 3 && bus.mdu_cnt !== 4'd3)) begin
                fails++; $display("FAIL rst_mid k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 60) == 0);
            tests++;
            if (got_v !== exp_v) begin
                fails++; $display("FAIL random k=%0d got=%h exp=%h", k, got_v, exp_v);
            end
`ifdef PIPE_STALL_CNT_EN
            tests++;
            if (stall_cycles !== m_stall || mdu_stall_cycles !== m_mdu) begin
                fails++; $display("FAIL random_perf k=%0d got=%0d/%0d exp=%0d/%0d", k, stall_cycles, mdu_stall_cycles, m_stall, m_mdu);
            end
`endif
            advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.hz_stall_D = 0; bus.mdu_use_D = 0; bus.mdu_start_E = 0; bus.mdu_is_div_E = 0;
        test_reset();
        test_hz_stall();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/bubble controller for the 5-stage pipeline.
- Combines the decode-stage load-use hazard request with a multi-cycle multiply/divide unit (MDU) busy sequencer.
- Drives the PC enable, the IF/ID register enable and the ID/EX bubble-insert clear.
- EX/MEM and MEM/WB registers are never stalled by this block; they advance every cycle.

Parameters:
- MULT_LAT, 5: cycles the MDU is busy for mult/multu; legal range 1..2^CNT_W-1.
- DIV_LAT, 10: cycles the MDU is busy for div/divu; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the busy countdown counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hz_stall_D  input  1  load-use/forwarding-impossible stall request from the hazard detector (combinational).
- mdu_use_D  input  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- mdu_start_E  input  1  mult/div instruction in E this cycle; valid for one cycle.
- mdu_is_div_E  input  1  qualifies mdu_start_E: 1 selects DIV_LAT, 0 selects MULT_LAT.
- pc_en  output  1  PC register write enable.
- ifid_en  output  1  IF/ID register write enable.
- idex_clr  output  1  ID/EX synchronous clear (inject NOP bubble).
- mdu_busy  output  1  MDU occupied (combinational).
- mdu_done  output  1  registered one-cycle pulse: HI/LO result final.
- mdu_cnt  output  CNT_W  remaining busy cycles (0 when idle).

Behaviour:
- FSM states: IDLE, BUSY. Reset (synchronous, wins over all inputs): state=IDLE, mdu_cnt=0, mdu_done=0.
- IDLE, at an edge with mdu_start_E=1: mdu_cnt <= (mdu_is_div_E ? DIV_LAT : MULT_LAT); state <= BUSY.
- BUSY, each edge: mdu_cnt <= mdu_cnt-1. At an edge with mdu_cnt==1: state <= IDLE, mdu_cnt <= 0, mdu_done <= 1.
- mdu_done is 0 on every other edge, so it is exactly one cycle wide, in the first IDLE cycle after BUSY.
- BUSY therefore lasts exactly LAT cycles following the start edge.
- mdu_start_E while in BUSY is a protocol violation (D is stalled, so it cannot occur legally). Required behaviour: ignore it; the counter is neither reloaded nor extended.
- mdu_busy = (state==BUSY) | mdu_start_E.
- stall = hz_stall_D | (mdu_use_D & mdu_busy).
- pc_en = ~stall; ifid_en = ~stall; idex_clr = stall. All combinational, same-cycle.
- With both stall causes active, a single stall results; no double bubble.
- mdu_start_E in the same cycle that mdu_done is high (state IDLE) is legal: a new BUSY period starts and mdu_done still pulses for the old op.
- Reset mid-BUSY aborts the operation: no mdu_done pulse is produced, and the next cycle is IDLE with mdu_cnt=0.
- During reset the combinational outputs follow their inputs; the pipeline registers are themselves reset.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [31:0]: increments by 1 on every edge where stall=1 and reset=0; wraps 0xFFFFFFFF -> 0.
  - Adds output mdu_stall_cycles [31:0]: increments when (mdu_use_D & mdu_busy & ~hz_stall_D); same wrap rule.
  - Both counters clear to 0 on reset.
- When undefined: neither port exists, no counter logic is generated, and all other behaviour is identical.

Test Plan:
- Reset, then idle inputs: pc_en=1, ifid_en=1, idex_clr=0, mdu_busy=0, mdu_cnt=0, mdu_done=0.
- hz_stall_D=1 for 2 cycles, no MDU activity: pc_en=0, ifid_en=0, idex_clr=1 in exactly those 2 cycles; FSM stays IDLE.
- mult: mdu_start_E=1, mdu_is_div_E=0 at cycle 0, and mdu_use_D=1 (mflo) held from cycle 0.
  - mdu_busy=1 in cycles 0..5; mdu_cnt reads 5,4,3,2,1 in cycles 1..5.
  - stall in cycles 0..5; mdu_done=1 in cycle 6 only; pc_en returns to 1 in cycle 6.
- div (DIV_LAT=10) with mdu_use_D=0: no stall at any point; mdu_cnt reads 10..1 in cycles 1..10; mdu_done=1 in cycle 11.
- Back-to-back: new mult start in the mdu_done cycle of a div.
  - mdu_done=1 and mdu_cnt reloads to 5 next edge; the illegal start injected mid-BUSY leaves mdu_cnt decrementing unchanged.
- Reset asserted when mdu_cnt=3: next cycle state IDLE, mdu_cnt=0, mdu_done never pulses.
- With PIPE_STALL_CNT_EN defined, the mult scenario above gives stall_cycles=6 and mdu_stall_cycles=6.
